// File: rtl/lcm_pkg.sv
// Shared definitions for the sequential LCM engine: FSM state encoding and default width.
package lcm_pkg;

    localparam int unsigned LCM_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lcm_state_t;

endpackage

// File: rtl/lcm_step.sv
// One running-sum step: advance the smaller multiple by its base operand, flag equality and carry-out.
module lcm_step #(
    parameter int unsigned N = lcm_pkg::LCM_N_DEFAULT
) (
    input  logic [N-1:0] i_ma,
    input  logic [N-1:0] i_mb,
    input  logic [N-1:0] i_ra,
    input  logic [N-1:0] i_rb,
    output logic [N-1:0] o_ma_nxt,
    output logic [N-1:0] o_mb_nxt,
    output logic         o_equal,
    output logic         o_carry
);

    logic [N:0] w_sum_a;
    logic [N:0] w_sum_b;

    assign w_sum_a = {1'b0, i_ma} + {1'b0, i_ra};
    assign w_sum_b = {1'b0, i_mb} + {1'b0, i_rb};

    always_comb begin
        o_equal  = (i_ma == i_mb);
        o_ma_nxt = i_ma;
        o_mb_nxt = i_mb;
        o_carry  = 1'b0;
        if (!o_equal) begin
            if (i_ma < i_mb) begin
                o_ma_nxt = w_sum_a[N-1:0];
                o_carry  = w_sum_a[N];
            end else begin
                o_mb_nxt = w_sum_b[N-1:0];
                o_carry  = w_sum_b[N];
            end
        end
    end

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM engine (running-sum, valid/ready both sides, overflow flag).
// Define LCM_CYCLE_CNT_EN to add the saturating RUN-edge counter output 'cycles'.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int unsigned N = LCM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] lcm,
`ifdef LCM_CYCLE_CNT_EN
    output logic [N-1:0] cycles,
`endif
    output logic         ovf
);

    lcm_state_t r_state;
    logic [N-1:0] r_ra, r_rb, r_ma, r_mb;
    logic [N-1:0] r_lcm;
    logic         r_ovf;
    logic         r_in_ready;
    logic         r_out_valid;
`ifdef LCM_CYCLE_CNT_EN
    logic [N-1:0] r_cycles;
`endif

    logic [N-1:0] w_ma_nxt, w_mb_nxt;
    logic         w_equal, w_carry;

    lcm_step #(.N(N)) u_step (
        .i_ma     (r_ma),
        .i_mb     (r_mb),
        .i_ra     (r_ra),
        .i_rb     (r_rb),
        .o_ma_nxt (w_ma_nxt),
        .o_mb_nxt (w_mb_nxt),
        .o_equal  (w_equal),
        .o_carry  (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ra        <= '0;
            r_rb        <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_lcm       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef LCM_CYCLE_CNT_EN
            r_cycles    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ra       <= a;
                        r_rb       <= b;
                        r_ma       <= a;
                        r_mb       <= b;
                        r_in_ready <= 1'b0;
`ifdef LCM_CYCLE_CNT_EN
                        r_cycles   <= '0;
`endif
                        // A zero operand short-circuits straight to a zero result.
                        if (a == '0 || b == '0) begin
                            r_state     <= DONE;
                            r_lcm       <= '0;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef LCM_CYCLE_CNT_EN
                    if (r_cycles != '1) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
`endif
                    if (w_equal) begin
                        r_state     <= DONE;
                        r_lcm       <= r_ma;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_carry) begin
                        r_state     <= DONE;
                        r_lcm       <= '0;
                        r_ovf       <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_ma <= w_ma_nxt;
                        r_mb <= w_mb_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign lcm       = r_lcm;
    assign ovf       = r_ovf;
`ifdef LCM_CYCLE_CNT_EN
    assign cycles    = r_cycles;
`endif

endmodule

// File: doc/lcm_seq.md
Name: lcm_seq

Overview:
- Sequential least-common-multiple engine for two unsigned N-bit operands; the dual of the team's combinational greatest-common-factor block.
- Uses a running-sum method with add and compare only: no divider, no multiplier.
- Valid/ready on the input and output sides, so it drops into the arithmetic datapath beside the factorial and overflow blocks.
- Flags results that do not fit in N bits.

Parameters:
- N, 16, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  engine can accept operands
- a  input  N  operand A, unsigned
- b  input  N  operand B, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- lcm  output  N  LCM(a,b); 0 when ovf=1 or when either operand is 0
- ovf  output  1  true LCM exceeds 2^N-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset (asserted at any time, including mid-computation):
  - state=IDLE; internal registers cleared.
  - in_ready=1, out_valid=0, lcm=0, ovf=0.
  - The in-flight operation is discarded, with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on a clock edge E with in_valid=1.
  - Latch ra=a, rb=b, ma=a, mb=b.
  - If a==0 or b==0: go to DONE with lcm=0, ovf=0. out_valid is high after edge E.
  - Otherwise go to RUN.
- RUN (in_ready=0). Each edge evaluates, with priority:
  1. ma==mb: go to DONE, lcm=ma, ovf=0.
  2. ma<mb: ma <= ma+ra. The sum is N+1 bits; if bit N is set, go to DONE with lcm=0, ovf=1.
  3. ma>mb: mb <= mb+rb, with the same carry rule.
- Latency:
  - With k add steps, out_valid is high after edge E+k+1.
  - a==b gives E+1.
  - Overflow: out_valid is high after the edge that produced the carry.
- DONE:
  - in_ready=0, out_valid=1.
  - lcm and ovf are held stable while out_ready=0; unbounded backpressure is allowed.
  - The edge with out_ready=1 returns the engine to IDLE; out_valid drops after that edge.
  - lcm and ovf keep their last value until the next result.
- There is no overlap between accept and output: a new accept is possible only in IDLE. Worst-case occupancy is about ra+rb edges.
- in_valid while busy is ignored, not queued. The producer holds in_valid until in_ready.
- Operands are captured only at accept. Changes on a/b afterwards have no effect.
- Arithmetic is unsigned only. The comparison uses the N-bit registered values.

Optional Feature:
- Macro LCM_CYCLE_CNT_EN.
- Defined:
  - Adds output port cycles, N bits.
  - Counts the RUN-state edges of the current operation and saturates at 2^N-1.
  - Cleared at accept; valid and held with out_valid.
  - 0 for zero-operand results.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package lcm_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default width constant.
- One sub-module, lcm_step: combinational.
  - Inputs: ma, mb, ra, rb.
  - Outputs: next ma, next mb, equal, carry.
- The FSM, handshake and optional counter stay in lcm_seq.

Test Plan:
- Basic, N=16: a=4, b=6 accepted at E, out_ready=1 -> out_valid after E+4, lcm=12, ovf=0; cycles=4 if LCM_CYCLE_CNT_EN.
- Equal operands: a=7, b=7 -> out_valid after E+1, lcm=7, ovf=0.
- Zero operand: a=0, b=5 -> out_valid after E, lcm=0, ovf=0. Same result for a=9, b=0.
- Overflow, N=8: a=255, b=254 -> ovf=1, lcm=0. Also a=12, b=18 -> lcm=36, ovf=0.
- Backpressure and busy:
  - a=3, b=5: out_ready held low 5 cycles after out_valid -> lcm=15 stable, in_ready=0.
  - in_valid with a=2, b=2 presented during RUN is ignored.
  - Accepted only after the out_ready handshake returns the engine to IDLE; result lcm=2.
- Reset mid-RUN: a=97, b=89, rst_n pulsed low for 1 cycle after 10 edges -> out_valid=0, lcm=0, ovf=0, in_ready=1 immediately. The next op a=4, b=10 gives lcm=20.
